load_align_unit: RTL
====================

Name: load_align_unit

Overview:
- Sequential load-alignment and extension unit between the MEM stage and a word-organised data memory.
- Accepts one load request at a time: byte address plus RISC-V funct3 load mode.
- Issues one or two word reads over a valid/ready port and merges words when a load crosses a word boundary.
- Returns the byte/half/word/dword result, sign- or zero-extended to XLEN, over a valid/ready port.

Parameters:
XLEN, 32, data/word width in bits; legal values 32 or 64; WB = XLEN/8 bytes per word, OW = log2(WB)
ADDR_W, 32, byte-address width

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
ld_valid  in  1  load request valid
ld_ready  out  1  unit can accept a request (high only in IDLE)
ld_addr  in  ADDR_W  byte address
ld_funct3  in  3  load mode: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU
mem_req_valid  out  1  memory read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  word-aligned address (low OW bits zero)
mem_rsp_valid  in  1  read data valid
mem_rsp_data  in  XLEN  read word
res_valid  out  1  result valid
res_ready  in  1  consumer accepts result
res_data  out  XLEN  extended result
res_err  out  1  illegal-mode or misaligned-not-supported flag; qualified by res_valid

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; mem_req_valid=0, res_valid=0, res_err=0, res_data=0, mem_req_addr=0; internal buffers cleared. ld_ready=1 once in IDLE.
- Reset mid-operation: transaction is abandoned; mem_rsp_valid seen in IDLE is ignored.
- Size S = 1 << funct3[1:0]; sign-extend when funct3[2]=0.
- off = addr[OW-1:0]; base = addr with low OW bits cleared.
- Split when off+S > WB.
- Illegal modes: 111; 011 and 110 when XLEN=32; 011 with funct3[2]=1.
- States:
  - IDLE: ld_valid&&ld_ready latches addr/funct3.
    - Illegal mode -> DONE with res_err=1, res_data=0, no memory access.
    - Legal -> REQ0.
  - REQ0: mem_req_valid=1, addr=base; on mem_req_ready -> RSP0.
  - RSP0: on mem_rsp_valid capture w0; split -> REQ1, else -> DONE.
  - REQ1: mem_req_valid=1, addr=base+WB (wraps modulo 2^ADDR_W); on ready -> RSP1.
  - RSP1: on mem_rsp_valid capture w1 -> DONE.
  - DONE: res_valid=1; res_data/res_err held stable until res_ready; on res_valid&&res_ready -> IDLE.
- Merge: m = ({w1,w0} >> (8*off)), take low S bytes, extend to XLEN (w1=0 if no split).
- Memory rules:
  - mem_req_addr is stable while mem_req_valid=1 and mem_req_ready=0.
  - Responses arrive in order, no earlier than the cycle after request acceptance.
  - Responses in REQ* states never occur; the bench must not drive them.
- Latency (all ready high, 1-cycle memory): aligned load res_valid 3 cycles after acceptance; split 5; illegal 1.
- No new request is accepted in the cycle a result retires (IDLE required).

Optional Feature:
- Macro LOAD_SPLIT_EN.
- Defined: boundary-crossing loads are split into two accesses as above.
- Undefined: REQ1/RSP1 are not built. A crossing load goes directly IDLE->DONE with res_err=1, res_data=0, no memory access. Non-crossing unaligned loads (e.g. LH off=1) still complete normally.

Test Plan:
1. XLEN=32, LB addr 0x103, rsp 0x80FF1234 -> single req addr 0x100; res_data=0xFFFFFF80, res_err=0; res_valid 3 cycles after accept.
2. LHU addr 0x102, rsp 0xBEEF0000 -> res_data=0x0000BEEF. LH addr 0x101, rsp 0x00F08000 -> 0xFFFFF080, one access.
3. LOAD_SPLIT_EN: LW addr 0x103, w0 0xAA000000, w1 0x11CCBBDD -> reqs 0x100 then 0x104; res_data=0xCCBBDDAA. Without macro: no reqs, res_err=1, res_data=0.
4. LOAD_SPLIT_EN: LH addr 0x103, w0 0x80000000, w1 0x000000F0 -> res_data=0xFFFFF080; LHU same -> 0x0000F080.
5. Backpressure: mem_req_ready low 3 cycles, res_ready low 2 cycles -> mem_req_addr and res_data stable throughout; ld_ready=0 until retire.
6. funct3=111 -> res_err=1 next cycle, no mem_req_valid. rst_n low during RSP0 -> outputs zero immediately; late mem_rsp_valid ignored; next LW addr 0x200 completes correctly.

Source files
------------

// File: rtl/load_align_unit.sv
// Load alignment and extension unit: fetches one or two memory words per load and returns the
// byte/half/word/dword result extended to XLEN. Macro LOAD_SPLIT_EN enables word-crossing loads.
module load_align_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_funct3,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [XLEN-1:0]   res_data,
    output logic              res_err
);

    localparam int WB = XLEN / 8;
    localparam int OW = $clog2(WB);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ0 = 3'd1,
        RSP0 = 3'd2,
`ifdef LOAD_SPLIT_EN
        REQ1 = 3'd3,
        RSP1 = 3'd4,
`endif
        DONE = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [XLEN-1:0]   resData_q, resData_d;
    logic              resErr_q, resErr_d;
`ifdef LOAD_SPLIT_EN
    logic [XLEN-1:0]   w0_q, w0_d;
`endif

    logic [OW-1:0]     off;
    logic [ADDR_W-1:0] base;

    // LD/LWU only exist on 64-bit datapaths; 111 is never a load.
    function automatic logic isIllegal(input logic [2:0] f3);
        logic bad;
        bad = (f3 == 3'b111);
        if (XLEN == 32 && (f3 == 3'b011 || f3 == 3'b110)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

    function automatic logic crossesWord(input logic [OW-1:0] offset, input logic [1:0] sizeCode);
        logic [OW+1:0] size;
        size = (OW+2)'(1) << sizeCode;
        return ((OW+2)'(offset) + size) > (OW+2)'(WB);
    endfunction

    // The pair {w1,w0} is shifted so the addressed byte lands at bit 0, then trimmed and extended.
    function automatic logic [XLEN-1:0] mergeLoad(input logic [2*XLEN-1:0] pair,
                                                  input logic [OW-1:0]     offset,
                                                  input logic [2:0]        f3);
        logic [XLEN-1:0] lo;
        logic [XLEN-1:0] ext;
        lo = XLEN'(pair >> {offset, 3'b000});
        case (f3[1:0])
            2'b00: begin
                if (f3[2]) ext = XLEN'(lo[7:0]);
                else       ext = XLEN'($signed(lo[7:0]));
            end
            2'b01: begin
                if (f3[2]) ext = XLEN'(lo[15:0]);
                else       ext = XLEN'($signed(lo[15:0]));
            end
            2'b10: begin
                if (f3[2]) ext = XLEN'(lo[31:0]);
                else       ext = XLEN'($signed(lo[31:0]));
            end
            default: ext = lo;
        endcase
        return ext;
    endfunction

    assign off  = addr_q[OW-1:0];
    assign base = {addr_q[ADDR_W-1:OW], {OW{1'b0}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            funct3_q  <= '0;
            resData_q <= '0;
            resErr_q  <= 1'b0;
`ifdef LOAD_SPLIT_EN
            w0_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            funct3_q  <= funct3_d;
            resData_q <= resData_d;
            resErr_q  <= resErr_d;
`ifdef LOAD_SPLIT_EN
            w0_q      <= w0_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        funct3_d      = funct3_q;
        resData_d     = resData_q;
        resErr_d      = resErr_q;
`ifdef LOAD_SPLIT_EN
        w0_d          = w0_q;
`endif
        ld_ready      = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        res_valid     = 1'b0;

        case (state_q)
            IDLE: begin
                ld_ready = 1'b1;
                if (ld_valid) begin
                    addr_d   = ld_addr;
                    funct3_d = ld_funct3;
`ifdef LOAD_SPLIT_EN
                    if (isIllegal(ld_funct3)) begin
`else
                    // Without split support a crossing load is rejected up front.
                    if (isIllegal(ld_funct3) ||
                        crossesWord(ld_addr[OW-1:0], ld_funct3[1:0])) begin
`endif
                        resData_d = '0;
                        resErr_d  = 1'b1;
                        state_d   = DONE;
                    end else begin
                        state_d = REQ0;
                    end
                end
            end

            REQ0: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = base;
                if (mem_req_ready) begin
                    state_d = RSP0;
                end
            end

            RSP0: begin
                if (mem_rsp_valid) begin
`ifdef LOAD_SPLIT_EN
                    if (crossesWord(off, funct3_q[1:0])) begin
                        w0_d    = mem_rsp_data;
                        state_d = REQ1;
                    end else begin
                        resData_d = mergeLoad({{XLEN{1'b0}}, mem_rsp_data}, off, funct3_q);
                        resErr_d  = 1'b0;
                        state_d   = DONE;
                    end
`else
                    resData_d = mergeLoad({{XLEN{1'b0}}, mem_rsp_data}, off, funct3_q);
                    resErr_d  = 1'b0;
                    state_d   = DONE;
`endif
                end
            end

`ifdef LOAD_SPLIT_EN
            REQ1: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = base + ADDR_W'(WB);
                if (mem_req_ready) begin
                    state_d = RSP1;
                end
            end

            RSP1: begin
                if (mem_rsp_valid) begin
                    resData_d = mergeLoad({mem_rsp_data, w0_q}, off, funct3_q);
                    resErr_d  = 1'b0;
                    state_d   = DONE;
                end
            end
`endif

            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    resData_d = '0;
                    resErr_d  = 1'b0;
                    state_d   = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign res_data = resData_q;
    assign res_err  = resErr_q;

endmodule
